// File: rtl/event_counter_bank.sv
// Bank of independent event counters sharing one terminal value, with wrap or
// saturate overflow handling and a 4-phase snapshot port that freezes all counts.
module event_counter_bank #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       clear,
  input  logic                      hold,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          limit,
  input  logic                      snap_req,
  output logic                      snap_ack,
  output logic [CHANNELS*WIDTH-1:0] snap_data,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       ovf
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } snap_state_t;

  logic [CHANNELS-1:0][WIDTH-1:0] r_count;
  logic [CHANNELS-1:0][WIDTH-1:0] w_count_inc;
  logic [CHANNELS-1:0][WIDTH-1:0] r_snap;
  logic [CHANNELS-1:0]            r_tc;
  logic [CHANNELS-1:0]            r_ovf;
  snap_state_t                    r_state;
  snap_state_t                    w_state_next;

  // Value a channel lands on when an increment finds it at or above limit.
  function automatic logic [WIDTH-1:0] terminal_value(input logic             sat_mode,
                                                      input logic [WIDTH-1:0] lim);
    return sat_mode ? lim : '0;
  endfunction

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_count_inc[i] = r_count[i] + 1'b1;
    end
  end

  // Counter channels: rst > clear > hold > inc.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        r_count[i] <= '0;
        r_ovf[i]   <= 1'b0;
        r_tc[i]    <= 1'b0;
      end else if (clear[i]) begin
        r_count[i] <= '0;
        r_ovf[i]   <= 1'b0;
        r_tc[i]    <= 1'b0;
      end else if (!hold && inc[i]) begin
        if (r_count[i] < limit) begin
          r_count[i] <= w_count_inc[i];
          r_tc[i]    <= (w_count_inc[i] == limit);
        end else begin
          // Also covers a limit lowered beneath a live count.
          r_count[i] <= terminal_value(mode, limit);
          r_ovf[i]   <= 1'b1;
          r_tc[i]    <= 1'b0;
        end
      end else begin
        r_tc[i] <= 1'b0;
      end
    end
  end

  // Snapshot handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (snap_req)  w_state_next = ST_ACK;
      ST_ACK:  if (!snap_req) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Captures the pre-update counts only on the IDLE->ACK edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap <= '0;
    end else if (r_state == ST_IDLE && snap_req) begin
      r_snap <= r_count;
    end
  end

  assign snap_ack  = (r_state == ST_ACK);
  assign snap_data = r_snap;
  assign count     = r_count;
  assign tc        = r_tc;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_event_counter_bank.sv
// Directed scoreboard bench for event_counter_bank (WIDTH=4, CHANNELS=2).
module tb_event_counter_bank;

  logic       clk;
  logic       rst;
  logic [1:0] inc;
  logic [1:0] clear;
  logic       hold;
  logic       mode;
  logic [3:0] limit;
  logic       snap_req;
  logic       snap_ack;
  logic [7:0] snap_data;
  logic [7:0] count;
  logic [1:0] tc;
  logic [1:0] ovf;

  int checks   = 0;
  int failures = 0;

  // Expected observation vector: {snap_ack, snap_data, count1, count0, tc, ovf}.
  logic [20:0] sb[$];

  event_counter_bank #(.WIDTH(4), .CHANNELS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc),
    .clear     (clear),
    .hold      (hold),
    .mode      (mode),
    .limit     (limit),
    .snap_req  (snap_req),
    .snap_ack  (snap_ack),
    .snap_data (snap_data),
    .count     (count),
    .tc        (tc),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] ex(input logic ack, input logic [7:0] snap,
                                     input logic [3:0] c1, input logic [3:0] c0,
                                     input logic [1:0] t, input logic [1:0] o);
    return {ack, snap, c1, c0, t, o};
  endfunction

  function automatic logic [20:0] obs();
    return {snap_ack, snap_data, count, tc, ovf};
  endfunction

  task automatic test_reset();
    logic [20:0] e;
    logic [20:0] o;
    rst = 1'b1; inc = 2'b11; clear = 2'b00; hold = 1'b0; mode = 1'b0;
    limit = 4'd3; snap_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(ex(1'b0, 8'h00, 4'd0, 4'd0, 2'b00, 2'b00));
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset cycle %0d: got %h expected %h", k, o, e);
      end
    end
    rst = 1'b0; inc = 2'b00; snap_req = 1'b0;
  endtask

  task automatic test_wrap();
    logic [20:0] e;
    logic [20:0] o;
    limit = 4'd3; mode = 1'b0; inc = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      sb.push_back(ex(1'b0, 8'h00, 4'd0, (k <= 3) ? 4'(k) : 4'(k - 4),
                      (k == 3) ? 2'b01 : 2'b00, (k >= 4) ? 2'b01 : 2'b00));
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap cycle %0d: got %h expected %h", k, o, e);
      end
    end
    inc = 2'b00; clear = 2'b11;
    sb.push_back(ex(1'b0, 8'h00, 4'd0, 4'd0, 2'b00, 2'b00));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL wrap_clear: got %h expected %h", o, e);
    end
    clear = 2'b00;
  endtask

  task automatic test_saturate();
    logic [20:0] e;
    logic [20:0] o;
    limit = 4'd3; mode = 1'b1; inc = 2'b10;
    for (int k = 1; k <= 6; k++) begin
      sb.push_back(ex(1'b0, 8'h00, (k < 3) ? 4'(k) : 4'd3, 4'd0,
                      (k == 3) ? 2'b10 : 2'b00, (k >= 4) ? 2'b10 : 2'b00));
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL saturate cycle %0d: got %h expected %h", k, o, e);
      end
    end
    inc = 2'b00; clear = 2'b11;
    @(posedge clk); #1;
    clear = 2'b00;
  endtask

  task automatic test_clear_hold();
    logic [20:0] e;
    logic [20:0] o;
    logic [1:0] t_inc[8] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    logic [1:0] t_clr[8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11};
    logic       t_hld[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] t_c1[8]  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1, 4'd0};
    logic [3:0] t_c0[8]  = '{4'd1, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
    logic [1:0] t_tc[8]  = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] t_ov[8]  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    limit = 4'd2; mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      inc = t_inc[k]; clear = t_clr[k]; hold = t_hld[k];
      sb.push_back(ex(1'b0, 8'h00, t_c1[k], t_c0[k], t_tc[k], t_ov[k]));
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL clear_hold step %0d: got %h expected %h", k, o, e);
      end
    end
    inc = 2'b00; clear = 2'b00; hold = 1'b0;
  endtask

  task automatic test_snapshot();
    logic [20:0] e;
    logic [20:0] o;
    limit = 4'd15; mode = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      inc = (k <= 5) ? 2'b11 : 2'b01;
      sb.push_back(ex(1'b0, 8'h00, (k <= 5) ? 4'(k) : 4'd5, 4'(k), 2'b00, 2'b00));
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL snap_setup cycle %0d: got %h expected %h", k, o, e);
      end
    end
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin snap_req = 1'b1; inc = 2'b00; sb.push_back(ex(1'b1, 8'h59, 4'd5, 4'd9, 2'b00, 2'b00)); end
        1: begin snap_req = 1'b1; inc = 2'b11; sb.push_back(ex(1'b1, 8'h59, 4'd6, 4'd10, 2'b00, 2'b00)); end
        2: begin snap_req = 1'b1; inc = 2'b11; sb.push_back(ex(1'b1, 8'h59, 4'd7, 4'd11, 2'b00, 2'b00)); end
        3: begin snap_req = 1'b0; inc = 2'b00; sb.push_back(ex(1'b0, 8'h59, 4'd7, 4'd11, 2'b00, 2'b00)); end
        default: begin snap_req = 1'b1; inc = 2'b00; sb.push_back(ex(1'b1, 8'h7B, 4'd7, 4'd11, 2'b00, 2'b00)); end
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL snapshot phase %0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  task automatic test_rst_mid_handshake();
    logic [20:0] e;
    logic [20:0] o;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin rst = 1'b1; snap_req = 1'b1; inc = 2'b11; sb.push_back(ex(1'b0, 8'h00, 4'd0, 4'd0, 2'b00, 2'b00)); end
        1: begin rst = 1'b0; snap_req = 1'b1; inc = 2'b01; sb.push_back(ex(1'b1, 8'h00, 4'd0, 4'd1, 2'b00, 2'b00)); end
        2: begin snap_req = 1'b0; inc = 2'b00; sb.push_back(ex(1'b0, 8'h00, 4'd0, 4'd1, 2'b00, 2'b00)); end
        default: begin clear = 2'b11; sb.push_back(ex(1'b0, 8'h00, 4'd0, 4'd0, 2'b00, 2'b00)); end
      endcase
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rst_mid phase %0d: got %h expected %h", k, o, e);
      end
    end
    clear = 2'b00;
  endtask

  task automatic test_limit_lower();
    logic [20:0] e;
    logic [20:0] o;
    for (int m = 1; m >= 0; m--) begin
      mode = m[0]; limit = 4'd15; inc = 2'b01;
      repeat (10) @(posedge clk);
      #1;
      inc = 2'b00; limit = 4'd4;
      sb.push_back(ex(1'b0, 8'h00, 4'd0, 4'd10, 2'b00, 2'b00));
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL limit_lower_hold mode %0d: got %h expected %h", m, o, e);
      end
      inc = 2'b01;
      sb.push_back(ex(1'b0, 8'h00, 4'd0, m[0] ? 4'd4 : 4'd0, 2'b00, 2'b01));
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL limit_lower_inc mode %0d: got %h expected %h", m, o, e);
      end
      inc = 2'b00; clear = 2'b11;
      @(posedge clk); #1;
      clear = 2'b00;
    end
  endtask

  task automatic test_limit_zero();
    logic [20:0] e;
    logic [20:0] o;
    limit = 4'd0; inc = 2'b11;
    for (int m = 0; m < 2; m++) begin
      mode = m[0];
      sb.push_back(ex(1'b0, 8'h00, 4'd0, 4'd0, 2'b00, 2'b11));
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL limit_zero mode %0d: got %h expected %h", m, o, e);
      end
    end
    inc = 2'b00; clear = 2'b11;
    @(posedge clk); #1;
    clear = 2'b00;
  endtask

  initial begin
    rst = 1'b1; inc = 2'b00; clear = 2'b00; hold = 1'b0; mode = 1'b0;
    limit = 4'd0; snap_req = 1'b0;
    test_reset();
    test_wrap();
    test_saturate();
    test_clear_hold();
    test_snapshot();
    test_rst_mid_handshake();
    test_limit_lower();
    test_limit_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/event_counter_bank.md
EVENT_COUNTER_BANK -- requirements
Module: event_counter_bank

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the bit width of each channel counter and of limit.
REQ-002 Parameter CHANNELS, default 2, SHALL set the number of independent counter channels.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-005 inc  in  CHANNELS  SHALL carry per-channel increment requests, one count per cycle sampled high.
REQ-006 clear  in  CHANNELS  SHALL carry per-channel synchronous clear requests.
REQ-007 hold  in  1  SHALL, when high, freeze all counters and ignore inc.
REQ-008 mode  in  1  SHALL select 0 = wrap, 1 = saturate.
REQ-009 limit  in  WIDTH  SHALL carry the terminal value, shared by all channels.
REQ-010 snap_req  in  1  SHALL be the snapshot request of a 4-phase handshake.
REQ-011 snap_ack  out  1  SHALL be the snapshot acknowledge.
REQ-012 snap_data  out  CHANNELS*WIDTH  SHALL hold captured counts; channel i at bits [i*WIDTH +: WIDTH].
REQ-013 count  out  CHANNELS*WIDTH  SHALL hold the live registered counts, same packing as snap_data.
REQ-014 tc  out  CHANNELS  SHALL be the per-channel terminal-count pulse.
REQ-015 ovf  out  CHANNELS  SHALL be the per-channel sticky overflow flag.

Function
REQ-016 Per-channel update priority SHALL be rst > clear[i] > hold > inc[i]; with none of these active, count[i] SHALL hold.
REQ-017 clear[i] SHALL set count[i]=0, ovf[i]=0, tc[i]=0 next cycle; other channels unaffected.
REQ-018 inc[i] with count[i] < limit SHALL set count[i] = count[i]+1 next cycle.
REQ-019 inc[i] with count[i] >= limit, mode=0, SHALL set count[i]=0 and ovf[i]=1.
REQ-020 inc[i] with count[i] >= limit, mode=1, SHALL set count[i]=limit and ovf[i]=1.
REQ-021 limit=0: every accepted inc SHALL leave count[i]=0 and set ovf[i]=1.
REQ-022 A limit lowered below a live count SHALL NOT change count until that channel's next accepted inc, which follows REQ-019/020.
REQ-023 Increment arithmetic SHALL be WIDTH bits; count SHALL never exceed max(limit, its value when limit was lowered).
REQ-024 tc[i] SHALL be high for exactly the one cycle after an accepted inc makes count[i] equal limit from below.
REQ-025 ovf[i] SHALL remain 1 until clear[i] or rst.
REQ-026 Snapshot FSM SHALL have states IDLE and ACK.
REQ-027 IDLE with snap_req=1 SHALL load snap_data with the current registered count (pre-update values of that edge), go to ACK, and drive snap_ack=1 from the next cycle.
REQ-028 ACK SHALL hold snap_ack=1 and snap_data stable while snap_req=1; snap_req=0 SHALL return to IDLE with snap_ack=0 next cycle.
REQ-029 A new capture SHALL require a return to IDLE; snap_req held high SHALL NOT recapture.
REQ-030 clear, hold and inc SHALL NOT alter snap_data outside a capture edge.

Reset
REQ-031 rst=1 at a clock edge SHALL set count=0, snap_data=0, tc=0, ovf=0, snap_ack=0, FSM=IDLE, overriding all other inputs.
REQ-032 rst asserted mid-handshake SHALL abort it; if snap_req is still 1 at the first edge with rst=0, a fresh capture SHALL occur per REQ-027.
REQ-033 Outputs before the first reset SHALL be unspecified; the bench SHALL apply rst for at least 1 cycle.

Verification (WIDTH=4, CHANNELS=2)
REQ-034 limit=3, mode=0, inc[0]=1 for 5 cycles -> count[0] 1,2,3,0,1; tc[0] high for 1 cycle after 3 is reached; ovf[0]=1 from the wrap.
REQ-035 limit=3, mode=1, inc[1]=1 for 6 cycles -> count[1] 1,2,3,3,3,3; ovf[1]=1; count[0] stays 0.
REQ-036 count[0]=2, inc[0]=1 with clear[0]=1 in the same cycle -> count[0]=0, ovf[0]=0; inc[0]=1 with hold=1 -> count unchanged.
REQ-037 count={5,9}, limit=15, snap_req 0->1 -> snap_ack=1 next cycle, snap_data={5,9}; then inc both while snap_req=1 -> snap_data unchanged; snap_req=0 -> snap_ack=0 next cycle.
REQ-038 count[0]=10, limit lowered to 4, mode=1, then one inc[0] -> count[0]=4, ovf[0]=1; same with mode=0 -> count[0]=0.
REQ-039 rst pulsed during ACK with snap_req held 1 -> all outputs 0 for that cycle; the next edge recaptures the current counts (0) and snap_ack=1 the following cycle.
